// File: rtl/lenet_pkg.sv
// Shared constants and types for the LeNet conv1 front end.
// Image geometry, kernel size, pixel width, derived window counts and
// the window generator's frame-sequencing states.
package lenet_pkg;

    localparam int IMG_W = 32;
    localparam int IMG_H = 32;
    localparam int K     = 5;
    localparam int DW    = 8;

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int N_WIN = OUT_W * OUT_H;

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int CRD_W = $clog2(OUT_W);
    localparam int WIN_W = K * K * DW;
    localparam int LB_W  = (K - 1) * DW;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/conv1_line_buf.sv
// Line buffer holding the K-1 most recent image rows.
// One word per image column; the word packs all K-1 rows at that column
// (row 0 = oldest in bits [DW-1:0]). A single write port updates a whole
// column and the read of that column is combinational.
module conv1_line_buf
    import lenet_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [COL_W-1:0] addr,
    input  logic [LB_W-1:0]  wdata,
    output logic [LB_W-1:0]  rdata
);

    logic [LB_W-1:0] mem [IMG_W];

    // Column write: the rows shift up by one as the new pixel enters.
    // NOTE: storage arrays get no reset so they map onto RAM; state registers
    // elsewhere use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/conv1_window_gen.sv
// Streaming KxK sliding-window generator feeding the conv1 PE array.
// Accepts one raster-order pixel per cycle, keeps K-1 rows in a line buffer
// and emits every valid stride-1 window as a flat bus (element e=K*r+c).
// Optional macro CONV1_WIN_COORD_EN adds win_row/win_col outputs giving the
// top-left coordinate of the window currently on win.
module conv1_window_gen
    import lenet_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DW-1:0]    pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [WIN_W-1:0] win,
    output logic             win_valid,
    input  logic             win_ready,
`ifdef CONV1_WIN_COORD_EN
    output logic [CRD_W-1:0] win_row,
    output logic [CRD_W-1:0] win_col,
`endif
    output logic             frame_done
);

    state_t           state, state_nxt;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [WIN_W-1:0] sr, sr_nxt;
    logic [LB_W-1:0]  lb_rdata, lb_wdata;
    logic             accept, load, win_hs, row_end, last_pix;

    assign accept   = pix_valid && pix_ready;
    assign win_hs   = win_valid && win_ready;
    assign row_end  = (col == COL_W'(IMG_W - 1));
    assign last_pix = row_end && (row == ROW_W'(IMG_H - 1));
    assign load     = accept && (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));

    // New pixel becomes the youngest row; the oldest row falls off the top.
    assign lb_wdata = {pix_in, lb_rdata[LB_W-1:DW]};

    conv1_line_buf u_line_buf (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (lb_wdata),
        .rdata (lb_rdata)
    );

    // Frame sequencing register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        pix_ready  = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                pix_ready = !win_valid || win_ready;
                if (pix_ready && pix_valid && last_pix) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!win_valid || win_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (state == IDLE && start) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (row_end) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Window contents after shifting in the column ending at the new pixel.
    always_comb begin
        sr_nxt = sr;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                sr_nxt[DW*(K*r+c) +: DW] = sr[DW*(K*r+c+1) +: DW];
            end
        end
        for (int r = 0; r < K - 1; r++) begin
            sr_nxt[DW*(K*r+K-1) +: DW] = lb_rdata[DW*r +: DW];
        end
        sr_nxt[DW*(K*K-1) +: DW] = pix_in;
    end

    // Shift register advances on every accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (accept) begin
            sr <= sr_nxt;
        end
    end

    // Output window register: loads completed windows, holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win       <= '0;
            win_valid <= 1'b0;
        end else if (load) begin
            win       <= sr_nxt;
            win_valid <= 1'b1;
        end else if (win_hs) begin
            win_valid <= 1'b0;
        end
    end

`ifdef CONV1_WIN_COORD_EN
    // Top-left coordinate of the window, loaded alongside win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_row <= '0;
            win_col <= '0;
        end else if (load) begin
            win_row <= CRD_W'(row - ROW_W'(K - 1));
            win_col <= CRD_W'(col - COL_W'(K - 1));
        end
    end
`endif

endmodule

// File: tb/tb_conv1_window_gen.sv
// Self-checking bench for conv1_window_gen: a golden image model pushes the
// expected window on each accepted pixel and the monitor pops it on each
// window handshake.
module tb_conv1_window_gen;
    import lenet_pkg::*;

    localparam int NPIX   = IMG_W * IMG_H;
    localparam int BUDGET = 20000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [DW-1:0]    pix_in;
    logic             pix_valid;
    logic             pix_ready;
    logic [WIN_W-1:0] win;
    logic             win_valid;
    logic             win_ready;
    logic             frame_done;
`ifdef CONV1_WIN_COORD_EN
    logic [CRD_W-1:0] win_row;
    logic [CRD_W-1:0] win_col;
`endif

    always #5 clk = ~clk;

    conv1_window_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .win        (win),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
`ifdef CONV1_WIN_COORD_EN
        .win_row    (win_row),
        .win_col    (win_col),
`endif
        .frame_done (frame_done)
    );

    typedef struct {
        logic [WIN_W-1:0] w;
        int               oy;
        int               ox;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] img [NPIX];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string tag, input logic [WIN_W-1:0] got,
                         input logic [WIN_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIN_W-1:0] model_win(input int oy, input int ox);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w[DW*(K*r+c) +: DW] = img[(oy + r) * IMG_W + ox + c];
            end
        end
        return w;
    endfunction

    // mode 0: ramp image, 1: random image. vprob/rprob: percent of cycles with
    // pix_valid / win_ready high. rst_after>0 resets after that many accepts.
    task automatic run_frame(input int mode, input int vprob, input int rprob,
                             input bit do_stall, input int rst_after);
        int               acc_cnt, win_cnt, done_cnt;
        int               pix44_step, last_step, done_step, stall_left;
        bit               stalled;
        logic [WIN_W-1:0] held;
        exp_t             e;

        for (int k = 0; k < NPIX; k++) begin
            img[k] = (mode == 0) ? DW'(k) : DW'($urandom);
        end
        acc_cnt = 0; win_cnt = 0; done_cnt = 0;
        pix44_step = -1; last_step = -1; done_step = -1;
        stall_left = 0; stalled = 1'b0; held = '0;

        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(negedge clk);
            // start at cycle 0 begins the frame; the later one lands in STREAM
            start     = (cyc == 0) || (mode == 1 && cyc == 200);
            pix_valid = (acc_cnt < NPIX) ? (int'($urandom_range(99)) < vprob) : 1'b1;
            pix_in    = img[acc_cnt % NPIX];
            if (do_stall && !stalled && acc_cnt >= 300 && win_valid) begin
                stalled    = 1'b1;
                stall_left = 10;
                held       = win;
            end
            if (stall_left > 0) begin
                win_ready = 1'b0;
            end else begin
                win_ready = int'($urandom_range(99)) < rprob;
            end
            #1;

            if (stall_left > 0) begin
                check("stall_pix_ready", WIN_W'(pix_ready), '0);
                check("stall_win_valid", WIN_W'(win_valid), WIN_W'(1));
                check("stall_win_hold", win, held);
                stall_left--;
            end
            if (pix44_step >= 0 && cyc == pix44_step + 1) begin
                check("first_win_latency", WIN_W'(win_valid), WIN_W'(1));
            end
            if (rprob == 100 && last_step >= 0 && cyc == last_step + 2) begin
                check("frame_done_timing", WIN_W'(frame_done), WIN_W'(1));
            end
            if (frame_done) begin
                done_cnt++;
                done_step = cyc;
            end

            if (win_valid && win_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_window", WIN_W'(win_valid), '0);
                end else begin
                    e = sb.pop_front();
                    check("win", win, e.w);
`ifdef CONV1_WIN_COORD_EN
                    check("win_row", WIN_W'(win_row), WIN_W'(e.oy));
                    check("win_col", WIN_W'(win_col), WIN_W'(e.ox));
                    if (win_cnt == 0) begin
                        check("coord_first_row", WIN_W'(win_row), '0);
                        check("coord_first_col", WIN_W'(win_col), '0);
                    end
                    if (win_cnt == OUT_W) begin
                        check("coord_29_row", WIN_W'(win_row), WIN_W'(1));
                        check("coord_29_col", WIN_W'(win_col), '0);
                    end
                    if (win_cnt == N_WIN - 1) begin
                        check("coord_last_row", WIN_W'(win_row), WIN_W'(OUT_H - 1));
                        check("coord_last_col", WIN_W'(win_col), WIN_W'(OUT_W - 1));
                    end
`endif
                    if (mode == 0 && win_cnt == 0) begin
                        check("ramp_first_e0",  WIN_W'(win[DW*0  +: DW]), WIN_W'(0));
                        check("ramp_first_e4",  WIN_W'(win[DW*4  +: DW]), WIN_W'(4));
                        check("ramp_first_e20", WIN_W'(win[DW*20 +: DW]), WIN_W'(128));
                        check("ramp_first_e24", WIN_W'(win[DW*24 +: DW]), WIN_W'(132));
                    end
                    if (mode == 0 && win_cnt == N_WIN - 1) begin
                        check("ramp_last_e24", WIN_W'(win[DW*24 +: DW]), WIN_W'(255));
                    end
                    win_cnt++;
                end
            end

            if (pix_valid && pix_ready) begin
                if (acc_cnt >= NPIX) begin
                    check("accept_after_frame", WIN_W'(pix_ready), '0);
                end else begin
                    int y, x;
                    y = acc_cnt / IMG_W;
                    x = acc_cnt % IMG_W;
                    if (y >= K - 1 && x >= K - 1) begin
                        e.oy = y - (K - 1);
                        e.ox = x - (K - 1);
                        e.w  = model_win(e.oy, e.ox);
                        sb.push_back(e);
                    end
                    if (y == K - 1 && x == K - 1) begin
                        pix44_step = cyc;
                        check("pre_first_win_valid", WIN_W'(win_valid), '0);
                    end
                    if (acc_cnt == NPIX - 1) begin
                        last_step = cyc;
                    end
                    acc_cnt++;
                end
                if (acc_cnt == rst_after) begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    check("midrst_win", win, '0);
                    check("midrst_win_valid", WIN_W'(win_valid), '0);
                    check("midrst_pix_ready", WIN_W'(pix_ready), '0);
                    check("midrst_frame_done", WIN_W'(frame_done), '0);
                    sb.delete();
                    @(negedge clk);
                    rst_n = 1'b1;
                    start = 1'b0;
                    return;
                end
            end

            if (done_step >= 0 && cyc >= done_step + 2) begin
                break;
            end
        end

        start = 1'b0;
        check("win_count", WIN_W'(win_cnt), WIN_W'(N_WIN));
        check("frame_done_pulses", WIN_W'(done_cnt), WIN_W'(1));
        check("pixels_accepted", WIN_W'(acc_cnt), WIN_W'(NPIX));
        check("scoreboard_empty", WIN_W'(sb.size()), '0);
    endtask

    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b1;
        pix_in    = '0;
        win_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_win", win, '0);
        check("rst_win_valid", WIN_W'(win_valid), '0);
        check("rst_pix_ready", WIN_W'(pix_ready), '0);
        check("rst_frame_done", WIN_W'(frame_done), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // IDLE ignores offered pixels
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            win_ready = 1'b1;
            pix_in    = DW'(i);
            #1;
            check("idle_pix_ready", WIN_W'(pix_ready), '0);
            check("idle_win_valid", WIN_W'(win_valid), '0);
        end

        run_frame(0, 100, 100, 1'b0, -1);
        run_frame(1, 100, 100, 1'b1, -1);
        run_frame(1, 50, 50, 1'b0, -1);
        run_frame(1, 50, 50, 1'b0, -1);
        run_frame(1, 70, 70, 1'b0, 500);
        run_frame(1, 80, 80, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
